mac_result_scheduler: RTL

MAC_RESULT_SCHEDULER -- requirements
Module: mac_result_scheduler

---
 rtl/mac_result_scheduler.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mac_result_scheduler.sv
// Collects ten upper-triangle MAC results of a 4x4 symmetric matrix
// and streams all sixteen elements row-major through a valid/ready port.
module mac_result_scheduler #(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              start,
  input  logic              mac1_valid,
  input  logic [3:0]        mac1_idx,
  input  logic [DATA_W-1:0] mac1_data,
  input  logic              mac2_valid,
  input  logic [3:0]        mac2_idx,
  input  logic [DATA_W-1:0] mac2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STREAM  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              h1_v_q, h1_v_d;
  logic [3:0]        h1_idx_q, h1_idx_d;
  logic [DATA_W-1:0] h1_dat_q, h1_dat_d;
  logic              h2_v_q, h2_v_d;
  logic [3:0]        h2_idx_q, h2_idx_d;
  logic [DATA_W-1:0] h2_dat_q, h2_dat_d;
  logic              rr_q, rr_d;
  logic [9:0]        flag_q, flag_d;
  logic [3:0]        oidx_q, oidx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [10];

  logic              gnt1, gnt2;
  logic              wr_en;
  logic [3:0]        wr_idx;
  logic [DATA_W-1:0] wr_dat;
  logic [15:0]       flag_ext;
  logic [3:0]        rd_idx;
  logic [1:0]        row, col, lo, hi;

  assign flag_ext = {6'b0, flag_q};

  always_comb begin
    state_d  = state_q;
    h1_v_d   = h1_v_q;
    h1_idx_d = h1_idx_q;
    h1_dat_d = h1_dat_q;
    h2_v_d   = h2_v_q;
    h2_idx_d = h2_idx_q;
    h2_dat_d = h2_dat_q;
    rr_d     = rr_q;
    flag_d   = flag_q;
    oidx_d   = oidx_q;
    err_d    = err_q;
    gnt1     = 1'b0;
    gnt2     = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = 4'd0;
    wr_dat   = '0;
    if (start) begin
      // start always restarts collection; same-cycle MAC results are lost
      state_d = COLLECT;
      h1_v_d  = 1'b0;
      h2_v_d  = 1'b0;
      rr_d    = 1'b0;
      flag_d  = '0;
      oidx_d  = 4'd0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mac1_valid || mac2_valid) err_d = 1'b1;
        end
        COLLECT: begin
          // rr_q=1 means MAC1 wins the next contested cycle
          if (h1_v_q && h2_v_q) begin
            gnt1 = rr_q;
            gnt2 = ~rr_q;
            rr_d = ~rr_q;
          end else begin
            gnt1 = h1_v_q;
            gnt2 = h2_v_q;
          end
          if (gnt1) begin
            h1_v_d = 1'b0;
            wr_idx = h1_idx_q;
            wr_dat = h1_dat_q;
          end else if (gnt2) begin
            h2_v_d = 1'b0;
            wr_idx = h2_idx_q;
            wr_dat = h2_dat_q;
          end
          if (gnt1 || gnt2) begin
            if (wr_idx > 4'd9 || flag_ext[wr_idx]) begin
              err_d = 1'b1;
            end else begin
              wr_en          = 1'b1;
              flag_d[wr_idx] = 1'b1;
            end
          end
          if (mac1_valid) begin
            if (!h1_v_q || gnt1) begin
              h1_v_d   = 1'b1;
              h1_idx_d = mac1_idx;
              h1_dat_d = mac1_data;
            end else begin
              err_d = 1'b1;
            end
          end
          if (mac2_valid) begin
            if (!h2_v_q || gnt2) begin
              h2_v_d   = 1'b1;
              h2_idx_d = mac2_idx;
              h2_dat_d = mac2_data;
            end else begin
              err_d = 1'b1;
            end
          end
          if (&flag_d) begin
            state_d = STREAM;
            h1_v_d  = 1'b0;
            h2_v_d  = 1'b0;
            oidx_d  = 4'd0;
          end
        end
        STREAM: begin
          if (mac1_valid || mac2_valid) err_d = 1'b1;
          if (out_ready) begin
            if (oidx_q == 4'd15) begin
              state_d = IDLE;
              oidx_d  = 4'd0;
            end else begin
              oidx_d = oidx_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q  <= IDLE;
      h1_v_q   <= 1'b0;
      h1_idx_q <= 4'd0;
      h1_dat_q <= '0;
      h2_v_q   <= 1'b0;
      h2_idx_q <= 4'd0;
      h2_dat_q <= '0;
      rr_q     <= 1'b0;
      flag_q   <= '0;
      oidx_q   <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      h1_v_q   <= h1_v_d;
      h1_idx_q <= h1_idx_d;
      h1_dat_q <= h1_dat_d;
      h2_v_q   <= h2_v_d;
      h2_idx_q <= h2_idx_d;
      h2_dat_q <= h2_dat_d;
      rr_q     <= rr_d;
      flag_q   <= flag_d;
      oidx_q   <= oidx_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_dat;
  end

  // mirror elements fold onto the upper-triangle entry
  assign row = oidx_q[3:2];
  assign col = oidx_q[1:0];
  assign lo  = (row < col) ? row : col;
  assign hi  = (row < col) ? col : row;

  always_comb begin
    rd_idx = 4'd0;
    unique case (lo)
      2'd0: rd_idx = {2'b00, hi};
      2'd1: rd_idx = 4'd3 + {2'b00, hi};
      2'd2: rd_idx = 4'd5 + {2'b00, hi};
      2'd3: rd_idx = 4'd9;
      default: rd_idx = 4'd0;
    endcase
  end

  assign out_valid = (state_q == STREAM);
  assign out_idx   = oidx_q;
  assign out_data  = mem_q[rd_idx];
  assign out_last  = out_valid && (oidx_q == 4'd15);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule
